dense_mac_engine: RTL and testbench



---
 rtl/dense_engine_pkg.sv | 39 +++
 rtl/dense_requant.sv | 27 ++
 rtl/dense_mac_engine.sv | 118 +++++++++++
 tb/tb_dense_mac_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_engine_pkg.sv
// Shared types and arithmetic helpers for the dense MAC engine family.
// Layer-specific weights live elsewhere; nothing here is layer-bound.
package dense_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FINAL,
        S_HOLD
    } state_t;

    function automatic int acc_w(input int width, input int n_in);
        return 2 * width + $clog2(n_in);
    endfunction

    // Round-half-up shift by nfrac, then clamp to a signed width-bit range.
    function automatic logic signed [63:0] sat_rshift(
        input logic signed [63:0] v,
        input int                 nfrac,
        input int                 width
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = v;
        if (nfrac > 0) begin
            r = (v + (64'sd1 <<< (nfrac - 1))) >>> nfrac;
        end
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/dense_requant.sv
// One neuron's output stage: bias add, rounding shift, saturation, activation.
module dense_requant
    import dense_engine_pkg::*;
#(
    parameter int                      ACC_W    = 37,
    parameter int                      WIDTH    = 16,
    parameter int                      NFRAC    = 10,
    parameter int                      ACT_MODE = 0,
    parameter logic signed [WIDTH-1:0] BIAS_J   = '0
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [WIDTH-1:0] o_res
);

    logic signed [63:0]      w_sum;
    logic signed [WIDTH-1:0] w_sat;

    always_comb begin
        w_sum = 64'(i_acc) + (64'(BIAS_J) <<< NFRAC);
        w_sat = WIDTH'(sat_rshift(w_sum, NFRAC, WIDTH));
        o_res = w_sat;
        if (ACT_MODE == 1 && w_sat[WIDTH-1]) begin
            o_res = '0;
        end
    end

endmodule

// File: rtl/dense_mac_engine.sv
// Streaming dense layer: one feature per accept, all neurons in parallel,
// result held until the consumer takes it.
module dense_mac_engine
    import dense_engine_pkg::*;
#(
    parameter int                      N_IN     = 32,
    parameter int                      N_OUT    = 5,
    parameter int                      WIDTH    = 16,
    parameter int                      NFRAC    = 10,
    parameter int                      ACT_MODE = 0,
    parameter logic signed [WIDTH-1:0] WEIGHTS [N_IN][N_OUT] = '{default: '0},
    parameter logic signed [WIDTH-1:0] BIAS [N_OUT] = '{default: '0}
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [WIDTH-1:0]  in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [N_OUT*WIDTH-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     len_err
);

    localparam int ACC_W = acc_w(WIDTH, N_IN);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc [N_OUT];
    logic [N_OUT*WIDTH-1:0]    r_out;
    logic                      r_len_err;

    logic                      w_accept;
    logic                      w_at_last;
    logic signed [2*WIDTH-1:0] w_prod [N_OUT];
    logic signed [ACC_W-1:0]   w_acc_nxt [N_OUT];
    logic signed [WIDTH-1:0]   w_res [N_OUT];
    logic [N_OUT*WIDTH-1:0]    w_res_flat;

    assign in_ready  = reset_n && (r_state == S_IDLE || r_state == S_ACCUM);
    assign w_accept  = in_valid && in_ready;
    // idx is 0 in IDLE, so this also covers the single-feature case.
    assign w_at_last = (r_idx == IDX_W'(N_IN - 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_at_last ? S_FINAL : S_ACCUM;
            S_ACCUM: if (w_accept && w_at_last) w_state_nxt = S_FINAL;
            S_FINAL: w_state_nxt = S_HOLD;
            S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_prod[j] = (2*WIDTH)'(in_data) * (2*WIDTH)'(WEIGHTS[r_idx][j]);
            w_acc_nxt[j] = (r_state == S_IDLE) ? ACC_W'(w_prod[j])
                                               : r_acc[j] + ACC_W'(w_prod[j]);
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        dense_requant #(
            .ACC_W    (ACC_W),
            .WIDTH    (WIDTH),
            .NFRAC    (NFRAC),
            .ACT_MODE (ACT_MODE),
            .BIAS_J   (BIAS[j])
        ) u_requant (
            .i_acc (r_acc[j]),
            .o_res (w_res[j])
        );
    end

    always_comb begin
        w_res_flat = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_res_flat[j*WIDTH +: WIDTH] = w_res[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_out     <= '0;
            r_len_err <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx <= w_at_last ? '0 : r_idx + 1'b1;
                for (int j = 0; j < N_OUT; j++) begin
                    r_acc[j] <= w_acc_nxt[j];
                end
                // Framing is by count; in_last only feeds the error flag.
                if (in_last != w_at_last) begin
                    r_len_err <= 1'b1;
                end
            end
            if (r_state == S_FINAL) begin
                r_out <= w_res_flat;
            end
        end
    end

    assign out_data  = r_out;
    assign out_valid = (r_state == S_HOLD);
    assign len_err   = r_len_err;

endmodule

// File: tb/tb_dense_mac_engine.sv
// Bench for dense_mac_engine: three engines share one input stream and are
// checked every cycle against an arithmetic model of the layer.
module tb_dense_mac_engine;

    typedef logic signed [15:0] w2_t [32][5];
    typedef logic signed [15:0] b_t [5];
    typedef logic signed [15:0] vec_t [32];
    typedef struct {
        logic [2:0][79:0] d;
        int               due;
    } exp_t;

    localparam w2_t W_A = '{default: '{default: 16'sh0400}};
    localparam b_t  B_A = '{default: 16'sh0000};
    localparam w2_t W_B = '{
        0:  '{16'sh0200, 16'sh0200, -16'sh0133, 16'sh00A1, 16'sh7FFF},
        5:  '{-16'sh0400, 16'sh0011, 16'sh0800, 16'sh8000, 16'sh0001},
        17: '{16'sh0123, -16'sh0200, 16'sh0000, 16'sh0400, -16'sh0001},
        31: '{16'sh7FFF, 16'sh0003, -16'sh0050, 16'sh0200, 16'sh0100},
        default: '{16'sh0100, -16'sh0080, 16'sh0040, -16'sh0020, 16'sh0010}};
    localparam b_t  B_B = '{16'shFFC0, 16'sh0000, 16'sh0050, -16'sh0100, 16'sh0007};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        rdy [3];
    logic [79:0] od [3];
    logic        ov [3];
    logic        le [3];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t q[$];
    bit   exp_len_err = 1'b0;
    bit   cur_seen = 1'b0;
    int   cur_dur = 0;
    bit   hold_req = 1'b0;
    bit   cur_held = 1'b0;
    int   hold_cnt = 0;
    int   held_dur = 0;
    logic [2:0][79:0] last_d = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dense_mac_engine #(.ACT_MODE(0), .WEIGHTS(W_A), .BIAS(B_A)) u0 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy[0]), .out_data(od[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .len_err(le[0]));
    dense_mac_engine #(.ACT_MODE(1), .WEIGHTS(W_B), .BIAS(B_B)) u1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy[1]), .out_data(od[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .len_err(le[1]));
    dense_mac_engine #(.ACT_MODE(0), .WEIGHTS(W_B), .BIAS(B_B)) u2 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy[2]), .out_data(od[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .len_err(le[2]));

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_lane(input vec_t xs, input int u, input int j);
        longint acc, r, w, b;
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            w = (u == 0) ? longint'(W_A[i][j]) : longint'(W_B[i][j]);
            acc += longint'(xs[i]) * w;
        end
        b = (u == 0) ? longint'(B_A[j]) : longint'(B_B[j]);
        r = (acc + b * 1024 + 512) >>> 10;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        if (u == 1 && r < 0) r = 0;
        return 16'(r);
    endfunction

    function automatic logic [79:0] model_vec(input vec_t xs, input int u);
        logic [79:0] v;
        v = '0;
        for (int j = 0; j < 5; j++) v[j*16 +: 16] = model_lane(xs, u, j);
        return v;
    endfunction

    task automatic fill(input logic [15:0] val, output vec_t v);
        for (int i = 0; i < 32; i++) v[i] = val;
    endtask

    task automatic rand_vec(input int mode, output vec_t v);
        for (int i = 0; i < 32; i++) begin
            if (mode == 0) v[i] = 16'($urandom);
            else v[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
        end
    endtask

    task automatic drive_feat(input logic [15:0] d, input bit l, output int acc_cyc);
        int n;
        @(negedge clk);
        while ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data = d;
        in_last = l;
        in_valid = 1'b1;
        n = 0;
        while (!rdy[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[0]) chk("accept_timeout", 80'(rdy[0]), 80'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_vec(input vec_t xs, input int last_at);
        exp_t e;
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            drive_feat(xs[i], (i == last_at), c);
            if ((i == last_at) != (i == 31)) exp_len_err = 1'b1;
        end
        for (int u = 0; u < 3; u++) e.d[u] = model_vec(xs, u);
        e.due = c + 2;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 80'(q.size()), 80'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        in_valid = 1'b0;
        q.delete();
        cur_seen = 1'b0;
        hold_cnt = 0;
        exp_len_err = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) chk("in_ready_in_reset", 80'(rdy[u]), 80'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            for (int u = 0; u < 3; u++) chk("len_err", 80'(le[u]), 80'(exp_len_err));
            if (ov[0] || ov[1] || ov[2]) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 80'({ov[0], ov[1], ov[2]}), 80'd0);
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    chk("out_valid", 80'({ov[0], ov[1], ov[2]}), 80'b111);
                    for (int u = 0; u < 3; u++) chk("out_data", od[u], q[0].d[u]);
                    chk("in_ready_hold", 80'(rdy[0]), 80'd0);
                    if (!cur_seen) begin
                        chk("latency", 80'(cyc), 80'(q[0].due));
                        cur_seen = 1'b1;
                        cur_dur = 0;
                        cur_held = hold_req;
                        if (hold_req) hold_cnt = 10;
                        hold_req = 1'b0;
                    end
                    cur_dur++;
                    if (hold_cnt > 0) begin
                        out_ready = 1'b0;
                        hold_cnt--;
                    end else begin
                        out_ready = 1'($urandom_range(0, 1));
                    end
                    if (out_ready) begin
                        last_d = q[0].d;
                        if (cur_held) held_dur = cur_dur;
                        void'(q.pop_front());
                        cur_seen = 1'b0;
                    end
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t xs;
        int c;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) chk("in_ready_in_reset", 80'(rdy[u]), 80'd0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("rst_out_data", od[u], 80'd0);
            chk("rst_out_valid", 80'(ov[u]), 80'd0);
            chk("rst_len_err", 80'(le[u]), 80'd0);
            chk("rst_in_ready", 80'(rdy[u]), 80'd1);
        end

        fill(16'h0200, xs); send_vec(xs, 31); drain();
        chk("half_sum_l0", 80'(last_d[0][15:0]), 80'h4000);
        chk("half_sum_l4", 80'(last_d[0][79:64]), 80'h4000);

        fill(16'h0400, xs); send_vec(xs, 31); drain();
        chk("sat_pos", 80'(last_d[0][31:16]), 80'h7FFF);
        fill(16'hFC00, xs); send_vec(xs, 31); drain();
        chk("sat_neg", 80'(last_d[0][47:32]), 80'h8000);

        fill(16'h0000, xs); send_vec(xs, 31); drain();
        chk("relu_bias", 80'(last_d[1][15:0]), 80'h0000);
        chk("lin_bias", 80'(last_d[2][15:0]), 80'hFFC0);

        fill(16'h0000, xs); xs[0] = 16'sh0001; send_vec(xs, 31); drain();
        chk("round_half_relu", 80'(last_d[1][31:16]), 80'h0001);
        chk("round_half_lin", 80'(last_d[2][31:16]), 80'h0001);
        chk("round_bias_neg", 80'(last_d[2][15:0]), 80'hFFC1);

        hold_req = 1'b1;
        rand_vec(1, xs); send_vec(xs, 31);
        rand_vec(1, xs); send_vec(xs, 31);
        drain();
        chk("hold_cycles", 80'(held_dur >= 11), 80'd1);

        rand_vec(1, xs); send_vec(xs, 5); drain();
        chk("len_err_early", 80'(le[0]), 80'd1);
        rand_vec(0, xs); send_vec(xs, 31); drain();

        rand_vec(1, xs);
        for (int i = 0; i < 17; i++) drive_feat(xs[i], 1'b0, c);
        do_reset();
        repeat (40) @(negedge clk);
        fill(16'h0200, xs); send_vec(xs, 31); drain();
        chk("after_reset", 80'(last_d[0][15:0]), 80'h4000);

        for (int k = 0; k < 8; k++) begin
            rand_vec(k % 2, xs);
            send_vec(xs, 31);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
